hamming_secded_serial_decoder: RTL and testbench

Parametrised serial Hamming decoder with optional SECDED (extended-parity) mode. It accepts one codeword bit per accepted cycle and computes the syndrome and overall parity. It corrects single-bit errors, flags uncorrectable ones, and presents the extracted data word on a valid/ready output handshake. It sits on the receive path after the bit-level UART receiver and generalises the fixed 7/4 decoder to any data width, with backpressure and error statistics.

---
 rtl/hamming_secded_serial_decoder.sv | 154 +++++++++++++++
 tb/tb_hamming_secded_serial_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_serial_decoder.sv
// Serial Hamming / SECDED decoder: collects one codeword bit per accepted cycle,
// corrects single errors, flags uncorrectable ones and keeps saturating error counts.
module hamming_secded_serial_decoder #(
    parameter int DATA_W = 4,
    parameter int SECDED = 1,
    parameter int CNT_W  = 8,
    localparam int P   = (DATA_W <= 1)  ? 2 :
                         (DATA_W <= 4)  ? 3 :
                         (DATA_W <= 11) ? 4 :
                         (DATA_W <= 26) ? 5 : 6,
    localparam int N_H = DATA_W + P,
    localparam int N   = N_H + SECDED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              frame_clr,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corrected,
    output logic              out_uncorrectable,
    output logic [P:0]        err_pos,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uerr_cnt,
    input  logic              cnt_clr
);

    localparam int IDX_W = $clog2(N + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {COLLECT, CHECK, HOLD} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [N-1:0]       cw;

    logic [P-1:0]       syn;
    logic               par;
    logic [N_H-1:0]     fixed;
    logic [DATA_W-1:0]  dec_data;
    logic               dec_corr;
    logic               dec_uncorr;
    logic [P:0]         dec_pos;
    int                 k;

    function automatic logic [CNT_W-1:0] sat_next(input logic [CNT_W-1:0] cur,
                                                  input logic inc, input logic clr);
        if (clr)
            return CNT_W'(inc);
        if (inc && (cur != '1))
            return cur + CNT_W'(1);
        return cur;
    endfunction

    assign in_ready = ena && (state == COLLECT);

    // Syndrome, overall parity and classification of the stored codeword.
    // A syndrome beyond N_H can only come from a shortened code and is never a single error.
    always_comb begin
        syn        = '0;
        par        = ^cw;
        fixed      = cw[N_H-1:0];
        dec_corr   = 1'b0;
        dec_uncorr = 1'b0;
        dec_pos    = '0;
        dec_data   = '0;
        k          = 0;
        for (int p = 1; p <= N_H; p++) begin
            if (cw[p-1])
                syn ^= P'(p);
        end
        if (SECDED != 0) begin
            if (syn == '0) begin
                if (par) begin
                    dec_corr = 1'b1;
                    dec_pos  = (P+1)'(N_H + 1);
                end
            end else if (par && (int'(syn) <= N_H)) begin
                dec_corr = 1'b1;
                dec_pos  = {1'b0, syn};
            end else begin
                dec_uncorr = 1'b1;
            end
        end else if (syn != '0) begin
            if (int'(syn) <= N_H) begin
                dec_corr = 1'b1;
                dec_pos  = {1'b0, syn};
            end else begin
                dec_uncorr = 1'b1;
            end
        end
        if (dec_corr && (syn != '0))
            fixed[int'(syn) - 1] = ~fixed[int'(syn) - 1];
        for (int p = 1; p <= N_H; p++) begin
            if ((p & (p - 1)) != 0) begin
                dec_data[k] = fixed[p-1];
                k = k + 1;
            end
        end
    end

    // Frame FSM; everything, including the counters, freezes while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= COLLECT;
            idx               <= '0;
            cw                <= '0;
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_corrected     <= 1'b0;
            out_uncorrectable <= 1'b0;
            err_pos           <= '0;
            corr_cnt          <= '0;
            uerr_cnt          <= '0;
        end else if (ena) begin
            corr_cnt <= sat_next(corr_cnt, (state == CHECK) && dec_corr, cnt_clr);
            uerr_cnt <= sat_next(uerr_cnt, (state == CHECK) && dec_uncorr, cnt_clr);
            case (state)
                COLLECT: begin
                    if (frame_clr) begin
                        idx <= '0;
                        cw  <= '0;
                    end else if (in_valid) begin
                        cw[idx] <= in_bit;
                        idx     <= idx + IDX_W'(1);
                        if (idx == LAST_IDX)
                            state <= CHECK;
                    end
                end
                CHECK: begin
                    out_data          <= dec_data;
                    out_corrected     <= dec_corr;
                    out_uncorrectable <= dec_uncorr;
                    err_pos           <= dec_pos;
                    out_valid         <= 1'b1;
                    state             <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        idx       <= '0;
                        state     <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_secded_serial_decoder.sv
// Directed, table-driven bench for the serial SECDED decoder (DATA_W=4, SECDED=1, CNT_W=8).
module tb_hamming_secded_serial_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       frame_clr;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_corrected;
    logic       out_uncorrectable;
    logic [3:0] err_pos;
    logic [7:0] corr_cnt;
    logic [7:0] uerr_cnt;
    logic       cnt_clr;

    int checks   = 0;
    int failures = 0;
    int exp_corr = 0;
    int exp_uerr = 0;

    // bits[0] is codeword position 1, the first bit on the wire.
    typedef struct packed {
        logic [7:0] bits;
        logic [3:0] data;
        logic       corr;
        logic       uncorr;
        logic [3:0] pos;
    } vec_t;

    vec_t vecs [8];

    hamming_secded_serial_decoder #(.DATA_W(4), .SECDED(1), .CNT_W(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ena               (ena),
        .frame_clr         (frame_clr),
        .in_valid          (in_valid),
        .in_bit            (in_bit),
        .in_ready          (in_ready),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_corrected     (out_corrected),
        .out_uncorrectable (out_uncorrectable),
        .err_pos           (err_pos),
        .corr_cnt          (corr_cnt),
        .uerr_cnt          (uerr_cnt),
        .cnt_clr           (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_counters(input vec_t v, input logic clr);
        if (clr) begin
            exp_corr = v.corr ? 1 : 0;
            exp_uerr = v.uncorr ? 1 : 0;
        end else begin
            if (v.corr && exp_corr < 255)
                exp_corr++;
            if (v.uncorr && exp_uerr < 255)
                exp_uerr++;
        end
    endtask

    // Shifts in one frame, checks the 2-edge latency and the decoded result; leaves it in HOLD.
    task automatic decode_and_check(input vec_t v, input logic clr, input int pause_at);
        int n;
        cnt_clr = clr;
        for (int i = 0; i < 8; i++) begin
            if (i == pause_at) begin
                for (int j = 0; j < 2; j++) begin
                    @(negedge clk);
                    ena      = 1'b0;
                    in_valid = 1'b1;
                    in_bit   = ~v.bits[i];
                    #1;
                    check_output("ena_low_in_ready", 32'(in_ready), 32'd0);
                end
            end
            @(negedge clk);
            ena      = 1'b1;
            in_valid = 1'b1;
            in_bit   = v.bits[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_output("valid_at_t", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_output("valid_at_t1", 32'(out_valid), 32'd1);
        cnt_clr = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output("out_valid", 32'(out_valid), 32'd1);
        model_counters(v, clr);
        check_output("out_data", 32'(out_data), 32'(v.data));
        check_output("out_corrected", 32'(out_corrected), 32'(v.corr));
        check_output("out_uncorrectable", 32'(out_uncorrectable), 32'(v.uncorr));
        check_output("err_pos", 32'(err_pos), 32'(v.pos));
        check_output("corr_cnt", 32'(corr_cnt), 32'(exp_corr));
        check_output("uerr_cnt", 32'(uerr_cnt), 32'(exp_uerr));
        check_output("hold_in_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic handshake();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_output("hs_valid_drop", 32'(out_valid), 32'd0);
        check_output("hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic apply_stimulus(input vec_t v, input logic clr);
        decode_and_check(v, clr, -1);
        handshake();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{bits: 8'h55, data: 4'hB, corr: 1'b0, uncorr: 1'b0, pos: 4'd0};
        vecs[1] = '{bits: 8'h45, data: 4'hB, corr: 1'b1, uncorr: 1'b0, pos: 4'd5};
        vecs[2] = '{bits: 8'hD5, data: 4'hB, corr: 1'b1, uncorr: 1'b0, pos: 4'd8};
        vecs[3] = '{bits: 8'h77, data: 4'hF, corr: 1'b0, uncorr: 1'b1, pos: 4'd0};
        vecs[4] = '{bits: 8'h00, data: 4'h0, corr: 1'b0, uncorr: 1'b0, pos: 4'd0};
        vecs[5] = '{bits: 8'h04, data: 4'h0, corr: 1'b1, uncorr: 1'b0, pos: 4'd3};
        vecs[6] = '{bits: 8'h54, data: 4'hB, corr: 1'b1, uncorr: 1'b0, pos: 4'd1};
        vecs[7] = '{bits: 8'h41, data: 4'h8, corr: 1'b0, uncorr: 1'b1, pos: 4'd0};

        rst_n     = 1'b0;
        ena       = 1'b1;
        frame_clr = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_out_data", 32'(out_data), 32'd0);
        check_output("rst_corrected", 32'(out_corrected), 32'd0);
        check_output("rst_uncorrectable", 32'(out_uncorrectable), 32'd0);
        check_output("rst_err_pos", 32'(err_pos), 32'd0);
        check_output("rst_corr_cnt", 32'(corr_cnt), 32'd0);
        check_output("rst_uerr_cnt", 32'(uerr_cnt), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            apply_stimulus(vecs[i], 1'b0);

        $display("[TB] backpressure");
        decode_and_check(vecs[0], 1'b0, -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bit   = ~in_bit;
            #1;
            check_output("bp_in_ready", 32'(in_ready), 32'd0);
            check_output("bp_out_valid", 32'(out_valid), 32'd1);
            check_output("bp_out_data", 32'(out_data), 32'hB);
            check_output("bp_corrected", 32'(out_corrected), 32'd0);
        end
        handshake();
        apply_stimulus(vecs[4], 1'b0);

        $display("[TB] ena freeze");
        decode_and_check(vecs[6], 1'b0, 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ena       = 1'b0;
            out_ready = 1'b1;
            #1;
            check_output("frz_in_ready", 32'(in_ready), 32'd0);
            check_output("frz_out_valid", 32'(out_valid), 32'd1);
            check_output("frz_err_pos", 32'(err_pos), 32'd1);
            check_output("frz_corr_cnt", 32'(corr_cnt), 32'(exp_corr));
        end
        @(negedge clk);
        ena       = 1'b1;
        out_ready = 1'b0;
        handshake();

        $display("[TB] frame_clr");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bit   = 1'b1;
        end
        @(negedge clk);
        frame_clr = 1'b1;
        in_valid  = 1'b1;
        in_bit    = 1'b1;
        @(negedge clk);
        frame_clr = 1'b0;
        in_valid  = 1'b0;
        apply_stimulus(vecs[0], 1'b0);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bit   = vecs[0].bits[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_corr = 0;
        exp_uerr = 0;
        check_output("mid_rst_corr_cnt", 32'(corr_cnt), 32'd0);
        check_output("mid_rst_uerr_cnt", 32'(uerr_cnt), 32'd0);
        check_output("mid_rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(vecs[0], 1'b0);

        $display("[TB] counter saturation");
        for (int i = 0; i < 257; i++)
            apply_stimulus(vecs[1], 1'b0);
        check_output("sat_corr_cnt", 32'(corr_cnt), 32'd255);
        apply_stimulus(vecs[1], 1'b1);
        check_output("clr_with_inc", 32'(corr_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
